// File: rtl/vga_mode_timing_pkg.sv
// Shared types and the constant video mode table for vga_mode_timing.
// Counter widths are derived from the largest totals in the table.
package vga_mode_timing_pkg;

  localparam int MODE_FIELD_W = 12;

  typedef struct packed {
    logic [MODE_FIELD_W-1:0] h_res;
    logic [MODE_FIELD_W-1:0] h_fp;
    logic [MODE_FIELD_W-1:0] h_sync;
    logic [MODE_FIELD_W-1:0] h_bp;
    logic [MODE_FIELD_W-1:0] v_res;
    logic [MODE_FIELD_W-1:0] v_fp;
    logic [MODE_FIELD_W-1:0] v_sync;
    logic [MODE_FIELD_W-1:0] v_bp;
    logic                    h_pol;
    logic                    v_pol;
  } vga_mode_t;

  function automatic logic [MODE_FIELD_W-1:0] mode_h_total(input vga_mode_t m);
    return m.h_res + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic logic [MODE_FIELD_W-1:0] mode_v_total(input vga_mode_t m);
    return m.v_res + m.v_fp + m.v_sync + m.v_bp;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam vga_mode_t MODE_640X480 = '{
    h_res: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_res: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
    h_pol: 1'b0,    v_pol: 1'b0
  };

  localparam vga_mode_t MODE_800X600 = '{
    h_res: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
    v_res: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
    h_pol: 1'b1,    v_pol: 1'b1
  };

  localparam vga_mode_t [1:0] VGA_MODE_TABLE = {MODE_800X600, MODE_640X480};

  localparam int H_TOTAL_MAX = max_int(int'(mode_h_total(MODE_640X480)),
                                       int'(mode_h_total(MODE_800X600)));
  localparam int V_TOTAL_MAX = max_int(int'(mode_v_total(MODE_640X480)),
                                       int'(mode_v_total(MODE_800X600)));

  localparam int X_POS_W = $clog2(H_TOTAL_MAX);
  localparam int Y_POS_W = $clog2(V_TOTAL_MAX);

endpackage

// File: rtl/vga_mode_timing_pixel_tick_gen.sv
// Pixel-rate tick: one registered pulse every DIV system clocks, constant high for DIV=1.
module pixel_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      if (div_cnt == LAST) div_cnt <= '0;
      else                 div_cnt <= div_cnt + CNT_W'(1);
      tick <= (div_cnt == LAST);
    end
  end

endmodule

// File: rtl/vga_mode_timing.sv
// Multi-mode VGA timing generator with frame-boundary mode switching.
// All video outputs are registered from the counter state, so they share one clock of latency.
module vga_mode_timing
  import vga_mode_timing_pkg::*;
#(
  parameter int                        BOARD_CLK_MHZ = 50,
  parameter int                        PIXEL_CLK_MHZ = 25,
  parameter int                        NUM_MODES     = 2,
  parameter int                        DEFAULT_MODE  = 0,
  parameter vga_mode_t [NUM_MODES-1:0] MODE_TABLE    = VGA_MODE_TABLE,
  localparam int                       SEL_W         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   mode_sel,
  input  logic               mode_req,
  output logic               mode_ack,
  output logic               mode_err,
  output logic [SEL_W-1:0]   mode_cur,
  output logic               pixel_en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [X_POS_W-1:0] x_pos,
  output logic [Y_POS_W-1:0] y_pos,
  output logic               frame_start,
  output logic               line_start
);

  localparam int        DIV     = BOARD_CLK_MHZ / PIXEL_CLK_MHZ;
  localparam vga_mode_t RST_CFG = MODE_TABLE[DEFAULT_MODE];

  logic                    tick;
  logic [X_POS_W-1:0]      h_cnt;
  logic [Y_POS_W-1:0]      v_cnt;
  logic                    pend_valid;
  logic [SEL_W-1:0]        pend_mode;
  vga_mode_t               cfg;
  logic [MODE_FIELD_W-1:0] hc, vc, h_sync_beg, h_sync_end, v_sync_beg, v_sync_end;
  logic                    h_last, v_last, h_in_sync, v_in_sync, req_valid;

  pixel_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    cfg        = MODE_TABLE[mode_cur];
    hc         = MODE_FIELD_W'(h_cnt);
    vc         = MODE_FIELD_W'(v_cnt);
    h_sync_beg = cfg.h_res + cfg.h_fp;
    h_sync_end = h_sync_beg + cfg.h_sync;
    v_sync_beg = cfg.v_res + cfg.v_fp;
    v_sync_end = v_sync_beg + cfg.v_sync;
    h_last     = (hc == mode_h_total(cfg) - MODE_FIELD_W'(1));
    v_last     = (vc == mode_v_total(cfg) - MODE_FIELD_W'(1));
    h_in_sync  = (hc >= h_sync_beg) && (hc < h_sync_end);
    v_in_sync  = (vc >= v_sync_beg) && (vc < v_sync_end);
    req_valid  = ({1'b0, mode_sel} < (SEL_W+1)'(NUM_MODES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_cur    <= SEL_W'(DEFAULT_MODE);
      pend_valid  <= 1'b0;
      pend_mode   <= '0;
      pixel_en    <= 1'b0;
      mode_ack    <= 1'b0;
      mode_err    <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      display_on  <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      hsync       <= ~RST_CFG.h_pol;
      vsync       <= ~RST_CFG.v_pol;
    end else begin
      pixel_en    <= tick;
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      line_start  <= tick && (h_cnt == '0);
      x_pos       <= h_cnt;
      y_pos       <= v_cnt;
      hsync       <= h_in_sync ? cfg.h_pol : ~cfg.h_pol;
      vsync       <= v_in_sync ? cfg.v_pol : ~cfg.v_pol;
      display_on  <= (hc < cfg.h_res) && (vc < cfg.v_res);
      mode_ack    <= 1'b0;
      mode_err    <= 1'b0;

      if (tick) begin
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt <= '0;
            if (pend_valid) begin
              mode_cur   <= pend_mode;
              pend_valid <= 1'b0;
              mode_ack   <= 1'b1;
            end
          end else begin
            v_cnt <= v_cnt + Y_POS_W'(1);
          end
        end else begin
          h_cnt <= h_cnt + X_POS_W'(1);
        end
      end

      // Placed after the apply logic so a request landing on the wrap tick stays pending.
      if (mode_req) begin
        if (req_valid) begin
          pend_mode  <= mode_sel;
          pend_valid <= 1'b1;
        end else begin
          mode_err <= 1'b1;
        end
      end
    end
  end

endmodule
